// File: rtl/color_code_scheduler.sv
// Round-robin scheduler sharing one digit-to-colour converter among NUM_REQ requesters.
// Optional macro COLOR_CODE_SKIP_UNCHANGED_EN: re-ack an unchanged value without reconverting.

module color_code_slot (
  input  logic        clk,
  input  logic        rst,
  input  logic        cap,
  input  logic [23:0] code_in,
`ifdef COLOR_CODE_SKIP_UNCHANGED_EN
  input  logic [5:0]  num_in,
  output logic [5:0]  last_num,
`endif
  output logic [23:0] code,
  output logic        valid
);
  always_ff @(posedge clk) begin
    if (rst) begin
      code  <= '0;
      valid <= 1'b0;
    end else if (cap) begin
      code  <= code_in;
      valid <= 1'b1;
    end
  end

`ifdef COLOR_CODE_SKIP_UNCHANGED_EN
  always_ff @(posedge clk) begin
    if (rst)      last_num <= '0;
    else if (cap) last_num <= num_in;
  end
`endif
endmodule

module color_code_scheduler #(
  parameter int NUM_REQ       = 3,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [6*NUM_REQ-1:0]   num_in,
  output logic [NUM_REQ-1:0]     ack,
  output logic [5:0]             conv_num,
  input  logic [23:0]            conv_code,
  output logic [24*NUM_REQ-1:0]  code_out,
  output logic [NUM_REQ-1:0]     code_valid,
  output logic                   busy
);
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, SETTLE, DONE} state_t;
  state_t state, state_nx;

  logic [PW-1:0] rr_ptr, g, grant, lo_idx, hi_idx;
  logic          lo_f, hi_f, found, hit;
  logic [3:0]    cnt;
  logic [NUM_REQ-1:0][5:0]  nums;
  logic [NUM_REQ-1:0][23:0] codes;
  logic [NUM_REQ-1:0]       cap;

  assign nums     = num_in;
  assign code_out = codes;
  assign busy     = (state != IDLE);

  // Cyclic priority: lowest index at/after rr_ptr wins, else wrap to lowest overall.
  always_comb begin
    lo_idx = '0;
    hi_idx = '0;
    lo_f   = 1'b0;
    hi_f   = 1'b0;
    for (int i = NUM_REQ-1; i >= 0; i--) begin
      if (req[i]) begin
        lo_idx = PW'(i);
        lo_f   = 1'b1;
        if (PW'(i) >= rr_ptr) begin
          hi_idx = PW'(i);
          hi_f   = 1'b1;
        end
      end
    end
    found = lo_f;
    grant = hi_f ? hi_idx : lo_idx;
  end

`ifdef COLOR_CODE_SKIP_UNCHANGED_EN
  logic [NUM_REQ-1:0][5:0] last_num;
  assign hit = found && code_valid[grant] && (nums[grant] == last_num[grant]);
`else
  assign hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (found) state_nx = hit ? DONE : SETTLE;
      SETTLE:  if (cnt == 4'd0) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr   <= '0;
      g        <= '0;
      cnt      <= '0;
      conv_num <= '0;
      ack      <= '0;
    end else begin
      case (state)
        IDLE: if (found) begin
          g <= grant;
          if (hit) begin
            ack        <= '0;
            ack[grant] <= 1'b1;
          end else begin
            conv_num <= nums[grant];
            cnt      <= 4'(SETTLE_CYCLES);
          end
        end
        SETTLE: begin
          if (cnt == 4'd0) begin
            ack    <= '0;
            ack[g] <= 1'b1;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE: begin
          ack    <= '0;
          rr_ptr <= (g == PW'(NUM_REQ-1)) ? '0 : g + 1'b1;
        end
        default: ack <= '0;
      endcase
    end
  end

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_slot
    assign cap[i] = (state == SETTLE) && (cnt == 4'd0) && (g == PW'(i));
    color_code_slot u_slot (
      .clk      (clk),
      .rst      (rst),
      .cap      (cap[i]),
      .code_in  (conv_code),
`ifdef COLOR_CODE_SKIP_UNCHANGED_EN
      .num_in   (conv_num),
      .last_num (last_num[i]),
`endif
      .code     (codes[i]),
      .valid    (code_valid[i])
    );
  end
endmodule
